// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - fetch handshake, branch request and shared-adder bundle for pc_seq
interface pc_seq_if;
  logic        imem_req;
  logic        imem_gnt;
  logic        instr_valid;
  logic        stall;
  logic        br_take;
  logic        br_jalr;
  logic [31:0] br_imm;
  logic [31:0] rs1_data;
  logic        trap;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic [31:0] pc;
  logic        misalign_err;
  logic [31:0] retire_cnt;

  // sequencer side
  modport master (
    output imem_req, add_a, add_b, pc, misalign_err, retire_cnt,
    input  imem_gnt, instr_valid, stall, br_take, br_jalr, br_imm, rs1_data, trap, add_sum
  );

  // core / memory / adder side
  modport slave (
    input  imem_req, add_a, add_b, pc, misalign_err, retire_cnt,
    output imem_gnt, instr_valid, stall, br_take, br_jalr, br_imm, rs1_data, trap, add_sum
  );
endinterface

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer: fetch handshake FSM, next-PC select, retire counter
module pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input logic       clk,
  input logic       rst_n,
  pc_seq_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        imem_req_q, imem_req_d;
  logic        misalign_err_q, misalign_err_d;
  logic [31:0] add_a, add_b;
  logic [31:0] target;

  // Operand steering for the shared adder; only a taken branch in UPD redirects it
  always_comb begin
    add_a = pc_q;
    add_b = 32'd4;
    if ((state_q == UPD) && !bus.trap && bus.br_take) begin
      add_a = bus.br_jalr ? bus.rs1_data : pc_q;
      add_b = bus.br_imm;
    end
  end

  // Next state, next PC and registered-output values
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    retire_cnt_d   = retire_cnt_q;
    misalign_err_d = 1'b0;
    // JALR clears bit 0 of the sum; the misalign test then looks at bit 1
    target         = bus.br_jalr ? {bus.add_sum[31:1], 1'b0} : bus.add_sum;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (bus.imem_gnt) state_d = WAIT;
      WAIT: if (bus.instr_valid) state_d = UPD;
      UPD: begin
        if (!bus.stall) begin
          state_d      = REQ;
          retire_cnt_d = retire_cnt_q + 32'd1;
          if (bus.trap) begin
            pc_d = TRAP_VEC;
          end else if (bus.br_take) begin
            if (target[1]) begin
              pc_d           = TRAP_VEC;
              misalign_err_d = 1'b1;
            end else begin
              pc_d = target;
            end
          end else begin
            pc_d = bus.add_sum;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // imem_req comes from a flop so add_sum can never reach it combinationally
    imem_req_d = (state_d == REQ);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      retire_cnt_q   <= 32'd0;
      imem_req_q     <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      retire_cnt_q   <= retire_cnt_d;
      imem_req_q     <= imem_req_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.pc           = pc_q;
  assign bus.retire_cnt   = retire_cnt_q;
  assign bus.misalign_err = misalign_err_q;
  assign bus.add_a        = add_a;
  assign bus.add_b        = add_b;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq against a next-PC reference model
module tb_pc_seq;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  pc_seq_if bus ();

  pc_seq #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // external shared adder
  assign bus.add_sum = bus.add_a + bus.add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // random values on inputs that must be ignored outside UPD
  task automatic junk();
    bus.stall    = 1'($urandom);
    bus.br_take  = 1'($urandom);
    bus.br_jalr  = 1'($urandom);
    bus.trap     = 1'($urandom);
    bus.br_imm   = $urandom;
    bus.rs1_data = $urandom;
  endtask

  task automatic clear_ctl();
    bus.stall    = 1'b0;
    bus.br_take  = 1'b0;
    bus.br_jalr  = 1'b0;
    bus.trap     = 1'b0;
    bus.br_imm   = 32'd0;
    bus.rs1_data = 32'd0;
  endtask

  // One full fetch/update round trip; starts and ends with the DUT in REQ
  task automatic instr(input int gw, input int vw, input int sn,
                       input logic tr, input logic bt, input logic jl,
                       input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_mis;
    check("req_hi", 32'(bus.imem_req), 32'd1);
    for (int i = 0; i < gw; i++) begin
      junk();
      bus.imem_gnt    = 1'b0;
      bus.instr_valid = 1'b0;
      step();
      check("req_hold", 32'(bus.imem_req), 32'd1);
      check("pc_hold_req", bus.pc, m_pc);
      check("add_a_req", bus.add_a, m_pc);
      check("add_b_req", bus.add_b, 32'd4);
    end
    junk();
    bus.imem_gnt    = 1'b1;
    bus.instr_valid = 1'($urandom);
    step();
    bus.imem_gnt    = 1'b0;
    bus.instr_valid = 1'b0;
    check("req_lo_wait", 32'(bus.imem_req), 32'd0);
    check("mis_clear", 32'(bus.misalign_err), 32'd0);
    for (int i = 0; i < vw; i++) begin
      junk();
      step();
      check("req_lo_wait2", 32'(bus.imem_req), 32'd0);
      check("pc_hold_wait", bus.pc, m_pc);
    end
    junk();
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.trap     = tr;
    bus.br_take  = bt;
    bus.br_jalr  = jl;
    bus.br_imm   = imm;
    bus.rs1_data = rs1;
    bus.stall    = 1'b1;
    for (int i = 0; i < sn; i++) begin
      step();
      check("stall_req", 32'(bus.imem_req), 32'd0);
      check("stall_pc", bus.pc, m_pc);
      check("stall_cnt", bus.retire_cnt, m_cnt);
    end
    bus.stall = 1'b0;
    #1;
    // reference model
    exp_mis = 1'b0;
    if (tr) begin
      exp_pc = TRAP_VEC;
    end else if (bt) begin
      tgt = jl ? ((rs1 + imm) & ~32'd1) : (m_pc + imm);
      if (tgt[1]) begin
        exp_pc  = TRAP_VEC;
        exp_mis = 1'b1;
      end else begin
        exp_pc = tgt;
      end
      check("add_a_br", bus.add_a, jl ? rs1 : m_pc);
      check("add_b_br", bus.add_b, imm);
    end else begin
      exp_pc = m_pc + 32'd4;
      check("add_a_seq", bus.add_a, m_pc);
      check("add_b_seq", bus.add_b, 32'd4);
    end
    step();
    m_pc  = exp_pc;
    m_cnt = m_cnt + 32'd1;
    clear_ctl();
    check("upd_pc", bus.pc, m_pc);
    check("upd_cnt", bus.retire_cnt, m_cnt);
    check("upd_mis", 32'(bus.misalign_err), 32'(exp_mis));
    check("upd_req", 32'(bus.imem_req), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.instr_valid = 1'b0;
    clear_ctl();
    m_pc  = RESET_PC;
    m_cnt = 32'd0;

    // reset state
    step();
    step();
    check("rst_pc", bus.pc, RESET_PC);
    check("rst_cnt", bus.retire_cnt, 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_mis", 32'(bus.misalign_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_req", 32'(bus.imem_req), 32'd0);
    step();
    check("first_req", 32'(bus.imem_req), 32'd1);

    // three sequential fetches
    for (int i = 0; i < 3; i++) instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("seq_pc12", bus.pc, 32'd12);
    check("seq_cnt3", bus.retire_cnt, 32'd3);

    // branches: 12 -> 0x40 -> 0x30 -> misaligned 0x36 -> TRAP_VEC
    instr(0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h34, 32'd0);
    check("jal_40", bus.pc, 32'h40);
    instr(0, 0, 0, 1'b0, 1'b1, 1'b0, -32'sd16, 32'd0);
    check("br_back", bus.pc, 32'h30);
    instr(0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h6, 32'd0);
    check("br_mis_pc", bus.pc, 32'h100);
    check("br_mis_pulse", 32'(bus.misalign_err), 32'd1);

    // JALR clears bit 0; trap beats branch
    instr(1, 1, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'h1001);
    check("jalr_pc", bus.pc, 32'h1000);
    instr(0, 0, 0, 1'b1, 1'b1, 1'b1, 32'd8, 32'h2000);
    check("trap_pc", bus.pc, 32'h100);

    // stall held five cycles, then one update
    instr(0, 0, 5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("stall_after", bus.pc, 32'h104);

    // grant withheld four cycles
    instr(4, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
            32'($urandom_range(0, 127)) - 32'd64, $urandom);
    end

    // PC and retire counter wrap
    instr(0, 0, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFC);
    check("pc_top", bus.pc, 32'hFFFF_FFFC);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    bus.imem_gnt = 1'b0;
    step();
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    check("cnt_preset", bus.retire_cnt, 32'hFFFF_FFFF);
    instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("pc_wrap", bus.pc, 32'd0);
    check("cnt_wrap", bus.retire_cnt, 32'd0);

    // reset asserted during WAIT, late instr_valid after release
    instr(0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h200, 32'd0);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    check("wait_req_lo", 32'(bus.imem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc, RESET_PC);
    check("arst_cnt", bus.retire_cnt, 32'd0);
    check("arst_req", 32'(bus.imem_req), 32'd0);
    bus.instr_valid = 1'b1;
    step();
    rst_n = 1'b1;
    m_pc  = RESET_PC;
    m_cnt = 32'd0;
    #1;
    check("rel_idle_req", 32'(bus.imem_req), 32'd0);
    step();
    check("rel_req", 32'(bus.imem_req), 32'd1);
    step();
    check("late_valid_ign", 32'(bus.imem_req), 32'd1);
    check("late_valid_pc", bus.pc, RESET_PC);
    bus.instr_valid = 1'b0;
    instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("post_rst_pc", bus.pc, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, the PC value loaded on trap or misaligned target.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  instruction fetch request, address = pc.
REQ-006 imem_gnt  in  1  fetch request accepted this cycle.
REQ-007 instr_valid  in  1  fetched instruction available this cycle.
REQ-008 stall  in  1  hold the sequencer in UPD without updating pc.
REQ-009 br_take  in  1  taken branch or JAL.
REQ-010 br_jalr  in  1  JALR, qualifies br_take.
REQ-011 br_imm  in  32  sign-extended immediate offset.
REQ-012 rs1_data  in  32  JALR base register value.
REQ-013 trap  in  1  exception or ecall request.
REQ-014 add_a, add_b  out  32 each  operands driven to the shared external PC adder.
REQ-015 add_sum  in  32  adder result, combinational from add_a/add_b.
REQ-016 pc  out  32  current program counter.
REQ-017 misalign_err  out  1  one-cycle pulse on misaligned target.
REQ-018 retire_cnt  out  32  count of completed PC updates.

Function
REQ-019 The block SHALL implement a 4-state FSM: IDLE, REQ, WAIT, UPD.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-021 In REQ, imem_req SHALL be 1; imem_gnt=1 moves to WAIT, otherwise stays in REQ.
REQ-022 In WAIT, imem_req SHALL be 0; instr_valid=1 moves to UPD.
REQ-023 instr_valid in the same cycle as imem_gnt SHALL be ignored; WAIT lasts at least one cycle.
REQ-024 In UPD with stall=1, the FSM SHALL remain in UPD and hold pc and retire_cnt.
REQ-025 In UPD with stall=0, pc SHALL load the next PC, retire_cnt SHALL increment by 1, and the FSM SHALL go to REQ.
REQ-026 Next-PC priority: trap, then br_take, then sequential.
REQ-027 trap=1: next PC = TRAP_VEC; adder operands are don't-care.
REQ-028 br_take=1 with br_jalr=1: add_a=rs1_data, add_b=br_imm; next PC = add_sum with bit 0 cleared.
REQ-029 br_take=1 with br_jalr=0: add_a=pc, add_b=br_imm; next PC = add_sum.
REQ-030 Otherwise: add_a=pc, add_b=32'd4; next PC = add_sum.
REQ-031 Outside UPD, add_a SHALL be pc and add_b SHALL be 32'd4.
REQ-032 br_jalr SHALL be ignored when br_take=0.
REQ-033 Adder arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.
REQ-034 A computed branch or JALR target with bit 1 set SHALL load TRAP_VEC and pulse misalign_err for the update cycle only.
REQ-035 retire_cnt SHALL increment on every non-stalled UPD, including trap and misaligned updates, and wrap 32'hFFFF_FFFF -> 0.
REQ-036 Branch, trap and stall inputs SHALL be sampled only in UPD.
REQ-037 No combinational path SHALL exist from add_sum to imem_req.

Reset
REQ-038 While rst_n=0: FSM=IDLE, pc=RESET_PC, retire_cnt=0, imem_req=0, misalign_err=0.
REQ-039 Reset assertion in any state SHALL abort immediately; an outstanding fetch is dropped and a late instr_valid after release SHALL be ignored until WAIT.

Verification
REQ-040 Reset release, imem_gnt=1, instr_valid 1 cycle later, no branch, repeated 3 times -> pc 0, 4, 8, 12; retire_cnt=3.
REQ-041 pc=32'h40, br_take=1, br_imm=-16 -> pc=32'h30; with br_imm=32'h6 -> pc=32'h100 and misalign_err pulse.
REQ-042 br_take=1, br_jalr=1, rs1_data=32'h1001, br_imm=0 -> pc=32'h1000; trap=1 together with br_take -> pc=32'h100.
REQ-043 stall=1 held 5 cycles in UPD -> pc and retire_cnt unchanged, imem_req=0; stall drop -> one update, then REQ.
REQ-044 imem_gnt held 0 for 4 cycles -> imem_req stays 1 and pc is stable; rst_n low during WAIT -> pc=RESET_PC and retire_cnt=0 asynchronously.
REQ-045 pc=32'hFFFF_FFFC sequential, and retire_cnt preset to 32'hFFFF_FFFF via a forced value -> pc=0 and retire_cnt=0 after the update.
